// File: rtl/hsid_pkg.sv
// Shared types and constants for the HSID iterative arithmetic blocks.
// The multiplier FSM state encoding lives here so checkers can see it.
package hsid_pkg;

  localparam int HSID_HSP_LIBRARY_WIDTH = 8;

  typedef enum logic [2:0] {
    HIM_IDLE,
    HIM_CLEAR,
    HIM_COMPUTE,
    HIM_CHECK,
    HIM_DONE
  } hsid_ite_mul_state_t;

endpackage

// File: rtl/hsid_multiplier_sva.sv
// Companion checker for hsid_multiplier: clear sequencing, fast paths,
// fixed latency (when HSID_MULTIPLIER_EARLY_EXIT_EN is undefined) and product value.
module hsid_multiplier_sva
  import hsid_pkg::*;
#(
  parameter int K = 32
) (
  input logic                clk,
  input logic                rst_n,
  input logic                clear,
  input logic                start,
  input logic                of_in,
  input logic [K-1:0]        multiplicand,
  input logic [K-1:0]        multiplier,
  input hsid_ite_mul_state_t state,
  input logic                idle,
  input logic                done,
  input logic [2*K-1:0]      product,
  input logic                overflow
);

  logic           accept;
  logic           zero_op;
  logic [2*K-1:0] exp_q;

  assign accept  = start && (state == HIM_IDLE) && !clear;
  assign zero_op = (multiplicand == '0) || (multiplier == '0);

  // Reference product of the operands seen at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else if (accept) begin
      exp_q <= {{K{1'b0}}, multiplicand} * {{K{1'b0}}, multiplier};
    end
  end

  a_clear_enters: assert property (@(posedge clk) disable iff (!rst_n)
    clear |=> state == HIM_CLEAR);

  a_clear_leaves: assert property (@(posedge clk) disable iff (!rst_n)
    (state == HIM_CLEAR && !clear) |=> idle);

  a_of_path: assert property (@(posedge clk) disable iff (!rst_n || clear)
    (accept && of_in) |=> (state == HIM_CHECK && overflow && product == '0) ##1 done);

  a_zero_path: assert property (@(posedge clk) disable iff (!rst_n || clear)
    (accept && !of_in && zero_op) |=> (state == HIM_CHECK && !overflow && product == '0) ##1 done);

`ifndef HSID_MULTIPLIER_EARLY_EXIT_EN
  a_fixed_latency: assert property (@(posedge clk) disable iff (!rst_n || clear)
    (accept && !of_in && !zero_op) |-> ##(K+2) done);
`endif

  a_product: assert property (@(posedge clk) disable iff (!rst_n)
    (done && !overflow) |-> product == exp_q);

  a_done_not_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !idle);

endmodule

// File: rtl/hsid_multiplier.sv
// Iterative radix-2 shift-add unsigned multiplier (K x K -> 2K) with divider-style handshake.
// Optional HSID_MULTIPLIER_EARLY_EXIT_EN: leave COMPUTE once the shifted multiplier is exhausted.
module hsid_multiplier
  import hsid_pkg::*;
#(
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter int K                 = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         start,
  input  logic [K-1:0]                 multiplicand,
  input  logic [K-1:0]                 multiplier,
  input  logic                         of_in,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_in,
  output logic                         idle,
  output logic                         ready,
  output logic                         done,
  output logic [2*K-1:0]               product,
  output logic                         overflow,
  output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_out
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  hsid_ite_mul_state_t          state_q, state_d;
  logic [2*K-1:0]               a_sh_q, a_sh_d;
  logic [K-1:0]                 b_q, b_d;
  logic [2*K-1:0]               acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [2*K-1:0]               product_q, product_d;
  logic                         of_q, of_d;
  logic [HSP_LIBRARY_WIDTH-1:0] hsp_q, hsp_d;
  logic                         last_iter;

`ifdef HSID_MULTIPLIER_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CW'(K-1)) || (b_q[K-1:1] == '0);
`else
  assign last_iter = (cnt_q == CW'(K-1));
`endif

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    of_d      = of_q;
    hsp_d     = hsp_q;

    if (clear) begin
      state_d   = HIM_CLEAR;
      acc_d     = '0;
      cnt_d     = '0;
      product_d = '0;
      of_d      = 1'b0;
      hsp_d     = '0;
    end else begin
      case (state_q)
        HIM_IDLE: begin
          if (start) begin
            a_sh_d    = {{K{1'b0}}, multiplicand};
            b_d       = multiplier;
            acc_d     = '0;
            cnt_d     = '0;
            product_d = '0;
            of_d      = of_in;
            hsp_d     = hsp_ref_in;
            // Overflowed or zero operands have a known result: skip the iterations.
            if (of_in || (multiplicand == '0) || (multiplier == '0)) begin
              state_d = HIM_CHECK;
            end else begin
              state_d = HIM_COMPUTE;
            end
          end
        end
        HIM_CLEAR: state_d = HIM_IDLE;
        HIM_COMPUTE: begin
          if (b_q[0]) begin
            acc_d = acc_q + a_sh_q;
          end
          a_sh_d = a_sh_q << 1;
          b_d    = b_q >> 1;
          cnt_d  = cnt_q + CW'(1);
          if (last_iter) begin
            state_d = HIM_CHECK;
          end
        end
        HIM_CHECK: begin
          product_d = of_q ? '0 : acc_q;
          state_d   = HIM_DONE;
        end
        HIM_DONE: state_d = HIM_IDLE;
        default:  state_d = HIM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HIM_IDLE;
      a_sh_q    <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      of_q      <= 1'b0;
      hsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      of_q      <= of_d;
      hsp_q     <= hsp_d;
    end
  end

  assign idle        = (state_q == HIM_IDLE);
  assign ready       = idle && !clear;
  assign done        = (state_q == HIM_DONE) && !clear;
  assign product     = product_q;
  assign overflow    = of_q;
  assign hsp_ref_out = hsp_q;

  hsid_multiplier_sva #(
    .K (K)
  ) u_sva (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .start        (start),
    .of_in        (of_in),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .state        (state_q),
    .idle         (idle),
    .done         (done),
    .product      (product),
    .overflow     (overflow)
  );

endmodule
